quad_step_gen: RTL and testbench
================================

QUAD_STEP_GEN -- requirements
Module: quad_step_gen

Interface
REQ-001 Parameter PHASE_CYCLES, default 100_000; clk cycles per quadrature quarter-phase; legal range 1..2^21-1.
REQ-002 Parameter POS_MIN, default 0; lower saturation bound of pos.
REQ-003 Parameter POS_MAX, default 36; upper saturation bound of pos.
REQ-004 Parameter POS_INIT, default 18; reset value of pos.
REQ-005 clk  input  1  single clock for all logic; reset rst is synchronous and active-high.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 step_valid  input  1  request one detent step.
REQ-008 step_dir  input  1  direction: 1 = CW, 0 = CCW; sampled only on acceptance.
REQ-009 step_ready  output  1  high when a new step can be accepted.
REQ-010 A  output  1  quadrature channel A, idle level 1.
REQ-011 B  output  1  quadrature channel B, idle level 1.
REQ-012 busy  output  1  high while a step waveform is in progress.
REQ-013 done  output  1  one-cycle pulse at the end of each step.
REQ-014 pos  output  6  emulated detent position, POS_MIN..POS_MAX.

Function
REQ-015 The FSM SHALL have states IDLE, Q1, Q2, Q3 and Q4.
REQ-016 In IDLE: step_ready=1, busy=0, A=1, B=1.
REQ-017 A step SHALL be accepted on the posedge where step_valid=1 and step_ready=1; step_dir is latched into an internal dir register at that edge.
REQ-018 On acceptance the FSM SHALL enter Q1 on the next cycle; A/B change exactly 1 cycle after the accepting edge.
REQ-019 CW output sequence (A,B): Q1=01, Q2=00, Q3=10, Q4=11. A therefore falls while B=1.
REQ-020 CCW output sequence (A,B): Q1=10, Q2=00, Q3=01, Q4=11. A therefore falls while B=0.
REQ-021 Each of Q1..Q4 SHALL last exactly PHASE_CYCLES cycles, counted by a 21-bit phase timer cleared on every state entry; one step occupies 4*PHASE_CYCLES cycles.
REQ-022 A and B SHALL be driven directly from registers, with no combinational path from inputs.
REQ-023 Only one of A or B SHALL change on any single clock edge.
REQ-024 busy=1 and step_ready=0 throughout Q1..Q4.
REQ-025 step_valid while busy SHALL be ignored and not queued.
REQ-026 On the last cycle of Q4 the FSM SHALL return to IDLE, and done SHALL pulse high for the first IDLE cycle.
REQ-027 pos SHALL update in the same cycle done is asserted: CCW increments, CW decrements.
REQ-028 pos SHALL saturate: a CCW step at POS_MAX leaves pos unchanged, and a CW step at POS_MIN leaves pos unchanged.
REQ-029 The waveform and done SHALL still be generated at saturation.
REQ-030 A new step SHALL be accepted in the same IDLE cycle that done is high; back-to-back steps are therefore separated by exactly one IDLE cycle at A=B=1.
REQ-031 With PHASE_CYCLES=1, each quarter-phase SHALL be exactly one cycle.

Reset
REQ-032 When rst=1 at a posedge, the block SHALL enter IDLE and set A=1, B=1, busy=0, done=0, step_ready=1, pos=POS_INIT, phase timer=0 and dir=0.
REQ-033 rst SHALL take priority over step_valid in the same cycle.
REQ-034 Reset mid-step SHALL abort the waveform immediately with no done pulse and no pos update.
REQ-035 The first cycle after rst deasserts SHALL accept a step.

Verification (PHASE_CYCLES=4, defaults otherwise)
REQ-036 Single CW step: (A,B) reads 01,00,10,11 for 4 cycles each, starting 1 cycle after acceptance; done pulses at cycle 17 after acceptance; pos goes 18 -> 17.
REQ-037 Single CCW step: (A,B) reads 10,00,01,11 for 4 cycles each; pos goes 18 -> 19.
REQ-038 19 consecutive CCW steps: pos saturates at 36 after the 18th; the 19th produces the full waveform and done, and pos stays 36. Mirror test with 19 CW steps: pos saturates at 0.
REQ-039 step_valid held high continuously: steps are accepted every 17 cycles; step_valid pulses during busy produce no extra steps.
REQ-040 rst asserted in Q2 of a CW step: next cycle A=B=1, busy=0, pos=18, no done; a step requested immediately after is accepted.
REQ-041 Loopback into the team's debounced quadrature reader (same clk, PHASE_CYCLES large enough to exceed the reader's debounce window): N CW steps produce N cw detections with the reader's count decremented by N, and CCW steps mirror this.

Source files
------------

// File: rtl/quad_step_gen_if.sv
// quad_step_gen_if: step request handshake plus quadrature/position outputs of the step generator.
interface quad_step_gen_if;
    logic       step_valid;
    logic       step_dir;
    logic       step_ready;
    logic       A;
    logic       B;
    logic       busy;
    logic       done;
    logic [5:0] pos;
    modport master (
        output step_valid, step_dir,
        input  step_ready, A, B, busy, done, pos
    );
    modport slave (
        input  step_valid, step_dir,
        output step_ready, A, B, busy, done, pos
    );
endinterface

// File: rtl/quad_step_gen.sv
// quad_step_gen: emits one quadrature detent waveform per accepted step and tracks a saturating position.
module quad_step_gen #(
    parameter int PHASE_CYCLES = 100_000,
    parameter int POS_MIN      = 0,
    parameter int POS_MAX      = 36,
    parameter int POS_INIT     = 18
) (
    input  logic           clk,
    input  logic           rst,
    quad_step_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, Q1, Q2, Q3, Q4} state_t;
    localparam logic [20:0] LAST  = 21'(PHASE_CYCLES - 1);
    localparam logic [5:0]  PMIN  = 6'(POS_MIN);
    localparam logic [5:0]  PMAX  = 6'(POS_MAX);
    localparam logic [5:0]  PINIT = 6'(POS_INIT);
    state_t      r_state, w_next;
    logic [20:0] r_timer;
    logic        r_dir, r_a, r_b, r_done;
    logic [5:0]  r_pos, w_pos;
    logic        w_last, w_accept, w_dir, w_a, w_b;
    always_comb begin
        w_last   = r_timer == LAST;
        w_accept = r_state == IDLE && bus.step_valid;
        w_dir    = w_accept ? bus.step_dir : r_dir;
        w_next   = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? Q1 : IDLE;
            Q1:      w_next = w_last ? Q2 : Q1;
            Q2:      w_next = w_last ? Q3 : Q2;
            Q3:      w_next = w_last ? Q4 : Q3;
            Q4:      w_next = w_last ? IDLE : Q4;
            default: w_next = IDLE;
        endcase
        // A/B are decoded from the upcoming state so they are registered in step with it
        w_a = w_next == Q1 ? ~w_dir : w_next == Q2 ? 1'b0 : w_next == Q3 ? w_dir : 1'b1;
        w_b = w_next == Q1 ? w_dir : w_next == Q2 ? 1'b0 : w_next == Q3 ? ~w_dir : 1'b1;
        w_pos = r_pos;
        if (r_state == Q4 && w_last)
            w_pos = r_dir ? (r_pos > PMIN ? r_pos - 6'd1 : r_pos)
                          : (r_pos < PMAX ? r_pos + 6'd1 : r_pos);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_dir   <= 1'b0;
            r_a     <= 1'b1;
            r_b     <= 1'b1;
            r_done  <= 1'b0;
            r_pos   <= PINIT;
        end else begin
            r_state <= w_next;
            r_timer <= (w_next != r_state || r_state == IDLE) ? '0 : r_timer + 21'd1;
            r_dir   <= w_dir;
            r_a     <= w_a;
            r_b     <= w_b;
            r_done  <= r_state == Q4 && w_last;
            r_pos   <= w_pos;
        end
    end
    assign bus.step_ready = r_state == IDLE;
    assign bus.busy       = r_state != IDLE;
    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.done       = r_done;
    assign bus.pos        = r_pos;
endmodule

// File: tb/tb_quad_step_gen.sv
// tb_quad_step_gen: vector table of step bursts checked cycle by cycle against a scoreboard queue.
module tb_quad_step_gen;
    localparam int PC = 4;
    typedef struct {
        logic [1:0] ab;
        logic       busy;
        logic       done;
        logic [5:0] pos;
    } exp_t;
    typedef struct {
        logic       rst_first;
        logic       dir;
        int         count;
        logic [5:0] exp_pos;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    logic [5:0] m_pos = 6'd18;
    logic [1:0] cw_ab[4];
    logic [1:0] ccw_ab[4];
    exp_t q[$];
    vec_t vecs[5];
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    quad_step_gen_if bus();
    quad_step_gen #(.PHASE_CYCLES(PC)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (chk_en) begin
            if (q.size() != 0) e = q.pop_front();
            else e = '{2'b11, 1'b0, 1'b0, m_pos};
            check("ab", {bus.A, bus.B}, e.ab);
            check("busy", bus.busy, e.busy);
            check("ready", bus.step_ready, !e.busy);
            check("done", bus.done, e.done);
            check("pos", bus.pos, e.pos);
        end
    end
    task automatic push_step(input logic d);
        logic [5:0] np;
        np = m_pos;
        if (d) begin
            if (np > 6'd0) np = np - 6'd1;
        end else if (np < 6'd36) np = np + 6'd1;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < PC; c++)
                q.push_back('{d ? cw_ab[i] : ccw_ab[i], 1'b1, 1'b0, m_pos});
        q.push_back('{2'b11, 1'b0, 1'b1, np});
        m_pos = np;
    endtask
    task automatic do_step(input logic d);
        int t;
        t = 0;
        while (!bus.step_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            check("ready_timeout", t, 0);
        end else begin
            bus.step_valid = 1'b1;
            bus.step_dir = d;
            @(posedge clk);
            push_step(d);
            #1;
            bus.step_valid = 1'b0;
            bus.step_dir = 1'($urandom);
        end
    endtask
    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", q.size(), 0);
        #1;
    endtask
    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        bus.step_valid = 1'b1;
        bus.step_dir = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.step_valid = 1'b0;
        q.delete();
        m_pos = 6'd18;
        chk_en = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        cw_ab  = '{2'b01, 2'b00, 2'b10, 2'b11};
        ccw_ab = '{2'b10, 2'b00, 2'b01, 2'b11};
        vecs[0] = '{1'b1, 1'b1, 1, 6'd17};
        vecs[1] = '{1'b0, 1'b0, 1, 6'd18};
        vecs[2] = '{1'b0, 1'b0, 19, 6'd36};
        vecs[3] = '{1'b1, 1'b1, 19, 6'd0};
        vecs[4] = '{1'b0, 1'b0, 1, 6'd1};
        bus.step_valid = 1'b0;
        bus.step_dir = 1'b0;
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rst_first) do_reset();
            for (int n = 0; n < vecs[v].count; n++) do_step(vecs[v].dir);
            drain();
            check("vec_pos", bus.pos, vecs[v].exp_pos);
        end
        // step_valid held high: accepts land every 17 cycles, dir only matters at acceptance
        bus.step_valid = 1'b1;
        for (int k = 0; k < 51; k++) begin
            bus.step_dir = (k % 17 == 0) ? 1'b1 : 1'($urandom);
            @(posedge clk);
            if (k % 17 == 0) push_step(1'b1);
            #1;
        end
        bus.step_valid = 1'b0;
        drain();
        check("held_pos", bus.pos, 6'd0);
        // reset during Q2 of a CW step, then step on the first free cycle
        do_reset();
        do_step(1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_pos = 6'd18;
        chk_en = 1'b1;
        @(negedge clk);
        check("midrst_pos", bus.pos, 6'd18);
        check("midrst_ab", {bus.A, bus.B}, 2'b11);
        do_step(1'b1);
        drain();
        check("post_rst_pos", bus.pos, 6'd17);
        do_step(1'b0);
        drain();
        check("final_pos", bus.pos, 6'd18);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
